// File: rtl/add_seq_pkg.sv
// Shared definitions for the sequential wide adder: FSM encoding and default sizing.
package add_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_N     = 8;
   localparam int DEF_WORDS = 4;

endpackage

// File: rtl/add_seq_ctrl_myadd.sv
// N-bit adder word slice: {cout, sum} = a + b + cin.
module myadd #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] full;

   // One wide add with the carry folded in; the top bit is the carry-out.
   always_comb begin
      full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
      sum  = full[N-1:0];
      cout = full[N];
   end

endmodule

// File: rtl/add_seq_ctrl.sv
// Sequential wide adder: one N-bit slice reused for WORDS cycles, LSB word first.
// Optional macro ADD_SEQ_SUB_EN adds a 'sub' input selecting a - b (a + ~b + 1).
module add_seq_ctrl
   import add_seq_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int WORDS = DEF_WORDS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N*WORDS-1:0] a,
   input  logic [N*WORDS-1:0] b,
   input  logic               cin,
`ifdef ADD_SEQ_SUB_EN
   input  logic               sub,
`endif
   output logic               busy,
   output logic               done,
   output logic [N*WORDS-1:0] sum,
   output logic               cout
);

   localparam int W  = N * WORDS;
   localparam int IW = $clog2(WORDS);
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   if (WORDS < 2 || WORDS > 16) begin : g_bad_words
      $error("add_seq_ctrl: WORDS must be in 2..16");
   end

   state_t         state;
   logic [W-1:0]   a_r;
   logic [W-1:0]   b_r;
   logic           carry;
   logic [IW-1:0]  idx;

   logic [N-1:0]   a_word;
   logic [N-1:0]   b_word;
   logic [N-1:0]   add_sum;
   logic           add_cout;

   // Select the operand words for the current index from the latched operands.
   always_comb begin
      a_word = a_r[idx*N +: N];
      b_word = b_r[idx*N +: N];
   end

   myadd #(.N(N)) u_add (
      .a    (a_word),
      .b    (b_word),
      .cin  (carry),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Control FSM with registered outputs; the carry register links successive words.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         carry <= 1'b0;
         a_r   <= '0;
         b_r   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_r <= a;
`ifdef ADD_SEQ_SUB_EN
                  // Subtraction inverts b and forces the +1 through the carry-in.
                  b_r   <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
`else
                  b_r   <= b;
                  carry <= cin;
`endif
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               sum[idx*N +: N] <= add_sum;
               carry           <= add_cout;
               idx             <= idx + IW'(1);
               if (idx == LAST) begin
                  cout  <= add_cout;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 8: width in bits of one adder word.
REQ-002 SHALL have parameter WORDS, default 4: number of words per operand; legal range 2..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request a new wide addition.
REQ-006 SHALL have ports a and b, input, N*WORDS bits each: wide operands.
REQ-007 SHALL have port cin, input, 1 bit: carry-in to word 0.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port sum, output, N*WORDS bits: registered wide result.
REQ-011 SHALL have port cout, output, 1 bit: registered carry-out of the top word.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 In IDLE with start high, SHALL on that edge latch a, b and cin into internal registers, clear the word index to 0, and go to RUN.
REQ-014 In RUN, SHALL on each edge write {carry, sum word[idx]} = a_word[idx] + b_word[idx] + carry, then increment idx.
  - carry = latched cin for word 0; registered carry-out of word idx-1 otherwise.
REQ-015 SHALL go RUN->DONE on the edge that writes word WORDS-1, and write cout on that same edge.
REQ-016 In DONE, SHALL assert done for exactly one cycle, then go to IDLE.
REQ-017 Latency: done SHALL be high in the cycle that starts WORDS edges after the edge that sampled start; the next start SHALL be accepted no earlier than WORDS+2 edges after the previous one.
REQ-018 SHALL hold busy high in RUN only, and hold done high in DONE only.
REQ-019 SHALL ignore start in RUN and DONE; latched operands SHALL NOT change while an operation is in progress.
REQ-020 SHALL allow a, b and cin to change freely after the start edge.
REQ-021 SHALL hold sum and cout stable from DONE until the first RUN write of the next operation; partially written sum words are visible during RUN.
REQ-022 Arithmetic: result SHALL be exactly (a + b + cin) mod 2^(N*WORDS), with cout as bit N*WORDS; no saturation.

Reset
REQ-023 rst high SHALL, on the next edge, force IDLE, set idx to 0, clear the carry, and drive busy=0, done=0, sum=0, cout=0.
REQ-024 rst SHALL take priority over start and over any in-flight operation; an aborted operation SHALL produce no done pulse.

Configuration
REQ-025 Macro ADD_SEQ_SUB_EN defined: SHALL add input port sub (1 bit), latched with the operands on start.
  - sub=1 computes a - b as a + ~b + 1: cin is ignored and cout=1 means no borrow.
REQ-026 Macro ADD_SEQ_SUB_EN undefined: SHALL have no sub port and SHALL perform addition only.

Structure
REQ-027 SHALL place the FSM state encodings and the default N and WORDS values in shared package add_seq_pkg.
REQ-028 SHALL instantiate exactly one N-bit adder sub-module, myadd (N-bit a, b, cin -> sum, cout), reused every RUN cycle; no other arithmetic on the datapath.

Verification (N=8, WORDS=4)
REQ-029 Carry ripple: a=0x000000FF, b=0x00000001, cin=0, start -> sum=0x00000100, cout=0, done exactly 4 edges after the start edge.
REQ-030 Full carry chain: a=0xFFFFFFFF, b=0, cin=1 -> sum=0x00000000, cout=1.
REQ-031 Busy rejection: start held high with new operands during RUN and DONE -> first result unchanged; second operation starts only from IDLE.
REQ-032 Reset mid-operation: rst at the edge after word 1 is written -> busy=0, done=0, sum=0, cout=0 next cycle; no done pulse follows.
REQ-033 With ADD_SEQ_SUB_EN: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0; a=7, b=5, sub=1 -> sum=0x00000002, cout=1.
REQ-034 Random back-to-back operations against a reference model -> every sum and cout matches; done pulses exactly once per accepted start.
